// File: rtl/bfp_mant_align.sv
// Block-floating-point mantissa alignment: captures an FP vector plus its shared exponent and streams
// P right-aligned signed-magnitude mantissas per beat. Define BFP_ROUND_EN for round-half-up instead of truncation.
module bfp_mant_align #(
    parameter int V    = 8,
    parameter int P    = 2,
    parameter int BIT  = 32,
    parameter int FPM  = 23,
    parameter int BFPM = 23
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [V-1:0][BIT-1:0]       i_invect,
    input  logic [BIT-FPM-2:0]          i_inExp,
    input  logic                        i_invect_rdy,
    output logic                        o_busy,
    output logic                        o_valid_out,
    output logic [P-1:0][BFPM-1:0]      o_mants,
    output logic [P-1:0]                o_signs,
    output logic [BIT-FPM-2:0]          o_outExp,
    output logic                        o_done,
    output logic                        o_overrun
);

    localparam int E  = BIT - FPM - 1;
    localparam int W  = FPM + 1;
    localparam int NB = V / P;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW = (V > 1) ? $clog2(V) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [BW-1:0]         r_beat;
    logic [V-1:0][BIT-1:0] r_vec;
    logic [E-1:0]          r_exp;
    logic                  r_overrun;
    logic                  w_lastBeat;

    // Align one element (sign stripped) to the shared exponent; denormals behave as exponent 1.
    function automatic logic [BFPM-1:0] alignMag(input logic [BIT-2:0] x, input logic [E-1:0] sharedExp);
        logic [E-1:0]    e;
        logic [E-1:0]    eEff;
        logic [E-1:0]    sh;
        logic [W-1:0]    m;
        logic [BFPM-1:0] mag;
`ifdef BFP_ROUND_EN
        logic [BFPM:0]   kept;
        logic [BFPM:0]   sum;
`endif
        e    = x[BIT-2:FPM];
        eEff = (e == '0) ? E'(1) : e;
        m    = {(e != '0), x[FPM-1:0]};
        sh   = (eEff > sharedExp) ? '0 : sharedExp - eEff;
`ifdef BFP_ROUND_EN
        // kept holds the top BFPM bits of the shifted mantissa plus the first dropped bit below them
        kept = (BFPM+1)'(({m, {W{1'b0}}} >> sh) >> (2*W - 1 - BFPM));
        sum  = {1'b0, kept[BFPM:1]} + {{BFPM{1'b0}}, kept[0]};
        mag  = sum[BFPM] ? {BFPM{1'b1}} : sum[BFPM-1:0];
`else
        mag  = BFPM'((m >> sh) >> (W - BFPM));
`endif
        return mag;
    endfunction

    assign w_lastBeat = (r_beat == LAST_BEAT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_vec     <= '0;
            r_exp     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IDLE && i_invect_rdy) begin
                r_vec  <= i_invect;
                r_exp  <= i_inExp;
                r_beat <= '0;
            end else if (r_state == S_EMIT && !w_lastBeat) begin
                r_beat <= r_beat + 1'b1;
            end
            if (r_state == S_EMIT && i_invect_rdy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // The beat counter parks on the last beat in IDLE so the lanes keep showing the final beat.
    always_comb begin
        w_nextState = r_state;
        o_busy      = 1'b0;
        o_valid_out = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_invect_rdy) begin
                    w_nextState = S_EMIT;
                end
            end
            S_EMIT: begin
                o_busy      = 1'b1;
                o_valid_out = 1'b1;
                if (w_lastBeat) begin
                    o_done      = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    assign o_outExp  = r_exp;
    assign o_overrun = r_overrun;

    for (genvar k = 0; k < P; k++) begin : g_lane
        logic [IW-1:0]   w_idx;
        logic [BIT-1:0]  w_elem;
        logic [BFPM-1:0] w_mag;

        assign w_idx       = IW'(int'(r_beat) * P + k);
        assign w_elem      = r_vec[w_idx];
        assign w_mag       = alignMag(w_elem[BIT-2:0], r_exp);
        assign o_mants[k]  = w_mag;
        assign o_signs[k]  = w_elem[BIT-1] & (w_mag != '0);
    end

endmodule

// File: tb/tb_bfp_mant_align.sv
// Directed self-checking bench for bfp_mant_align (V=8, P=2); expectations follow BFP_ROUND_EN when defined.
module tb_bfp_mant_align;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0][31:0]     invect;
    logic [7:0]           inExp;
    logic                 invectRdy;
    logic                 busy;
    logic                 validOut;
    logic [1:0][22:0]     mants;
    logic [1:0]           signs;
    logic [7:0]           outExp;
    logic                 done;
    logic                 overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0][31:0] vecA;
    logic [7:0][31:0] vecB;
    logic [22:0]      expRound;

    always #5 clk = ~clk;

    bfp_mant_align dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_invect     (invect),
        .i_inExp      (inExp),
        .i_invect_rdy (invectRdy),
        .o_busy       (busy),
        .o_valid_out  (validOut),
        .o_mants      (mants),
        .o_signs      (signs),
        .o_outExp     (outExp),
        .o_done       (done),
        .o_overrun    (overrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    task automatic checkBeat(input string tag, input logic [22:0] m0, input logic [22:0] m1,
                             input logic [1:0] s, input logic d);
        checkOutput({tag, "_valid"}, 32'(validOut), 32'd1);
        checkOutput({tag, "_mant0"}, 32'(mants[0]), 32'(m0));
        checkOutput({tag, "_mant1"}, 32'(mants[1]), 32'(m1));
        checkOutput({tag, "_signs"}, 32'(signs), 32'(s));
        checkOutput({tag, "_done"},  32'(done), 32'(d));
    endtask

    // Called on a falling edge; the strobe is seen by exactly one rising edge, then beat 0 is visible.
    task automatic applyStimulus(input logic [7:0][31:0] vec, input logic [7:0] e);
        invect    = vec;
        inExp     = e;
        invectRdy = 1'b1;
        @(negedge clk);
        invectRdy = 1'b0;
    endtask

    task automatic finishVector(input string tag, input int remaining);
        repeat (remaining) @(negedge clk);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_idle"}, 32'(validOut), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        invectRdy = 1'b0;
        invect    = '0;
        inExp     = '0;
        vecA = {32'h40900000, 32'h40600000, 32'h40200000, 32'h3FC00000,
                32'h40900000, 32'h40600000, 32'h40200000, 32'h3FC00000};
`ifdef BFP_ROUND_EN
        expRound = 23'h400001;
`else
        expRound = 23'h400000;
`endif
        repeat (2) @(negedge clk);
        checkOutput("rst_valid",   32'(validOut), 32'd0);
        checkOutput("rst_busy",    32'(busy),     32'd0);
        checkOutput("rst_done",    32'(done),     32'd0);
        checkOutput("rst_overrun", 32'(overrun),  32'd0);
        checkOutput("rst_mants",   32'(mants),    32'd0);
        checkOutput("rst_signs",   32'(signs),    32'd0);
        checkOutput("rst_outExp",  32'(outExp),   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic four-beat stream
        applyStimulus(vecA, 8'd129);
        checkOutput("t1_outExp", 32'(outExp), 32'd129);
        checkOutput("t1_busy",   32'(busy),   32'd1);
        checkBeat("t1_b0", 23'h180000, 23'h280000, 2'b00, 1'b0);
        @(negedge clk);
        checkBeat("t1_b1", 23'h380000, 23'h480000, 2'b00, 1'b0);
        @(negedge clk);
        checkBeat("t1_b2", 23'h180000, 23'h280000, 2'b00, 1'b0);
        @(negedge clk);
        checkBeat("t1_b3", 23'h380000, 23'h480000, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("t1_idleValid", 32'(validOut), 32'd0);
        checkOutput("t1_idleBusy",  32'(busy),     32'd0);
        checkOutput("t1_idleDone",  32'(done),     32'd0);
        checkOutput("t1_holdMant1", 32'(mants[1]), 32'h480000);
        checkOutput("t1_holdExp",   32'(outExp),   32'd129);

        // Negative element
        vecB    = vecA;
        vecB[1] = 32'hC0200000;
        applyStimulus(vecB, 8'd129);
        checkBeat("t2_b0", 23'h180000, 23'h280000, 2'b10, 1'b0);
        @(negedge clk);
        checkBeat("t2_b1", 23'h380000, 23'h480000, 2'b00, 1'b0);
        finishVector("t2", 2);

        // Zero and full underflow, including negative values that must not produce negative zero
        vecB    = vecA;
        vecB[0] = 32'h00000000;
        vecB[1] = 32'hBF800000;
        applyStimulus(vecB, 8'd157);
        checkBeat("t3_b0", 23'h0, 23'h0, 2'b00, 1'b0);
        @(negedge clk);
        checkBeat("t3_b1", 23'h0, 23'h0, 2'b00, 1'b0);
        finishVector("t3", 2);

        // Rounding, saturation and an element exponent above the shared one
        vecB    = '0;
        vecB[0] = 32'h3F800001;
        vecB[1] = 32'h3FFFFFFF;
        vecB[2] = 32'h40000000;
        vecB[3] = 32'h3F000000;
        applyStimulus(vecB, 8'd127);
        checkBeat("t4_b0", expRound, 23'h7FFFFF, 2'b00, 1'b0);
        @(negedge clk);
        checkBeat("t4_b1", 23'h400000, 23'h200000, 2'b00, 1'b0);
        finishVector("t4", 2);

        // Denormal uses effective exponent 1
        vecB    = '0;
        vecB[0] = 32'h00400000;
        vecB[1] = 32'h80800000;
        applyStimulus(vecB, 8'd1);
        checkBeat("t7_b0", 23'h200000, 23'h400000, 2'b10, 1'b0);
        finishVector("t7", 3);

        // Strobes while busy are ignored and set the sticky overrun flag
        vecB = {8{32'h3F800000}};
        applyStimulus(vecA, 8'd129);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_overrunBefore", 32'(overrun), 32'd0);
        checkBeat("t5_b2", 23'h180000, 23'h280000, 2'b00, 1'b0);
        invect    = vecB;
        inExp     = 8'd127;
        invectRdy = 1'b1;
        @(negedge clk);
        checkBeat("t5_b3", 23'h380000, 23'h480000, 2'b00, 1'b1);
        checkOutput("t5_overrun", 32'(overrun), 32'd1);
        checkOutput("t5_exp",     32'(outExp),  32'd129);
        @(negedge clk);
        invectRdy = 1'b0;
        checkOutput("t5_doneStrobeIgnored", 32'(validOut), 32'd0);
        checkOutput("t5_busyLow",           32'(busy),     32'd0);
        applyStimulus(vecB, 8'd127);
        checkBeat("t5_new_b0", 23'h400000, 23'h400000, 2'b00, 1'b0);
        checkOutput("t5_overrunSticky", 32'(overrun), 32'd1);
        finishVector("t5_new", 3);

        // Asynchronous reset in the middle of beat 2
        applyStimulus(vecA, 8'd129);
        @(negedge clk);
        @(negedge clk);
        checkBeat("t6_b2", 23'h180000, 23'h280000, 2'b00, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_valid",   32'(validOut), 32'd0);
        checkOutput("t6_busy",    32'(busy),     32'd0);
        checkOutput("t6_done",    32'(done),     32'd0);
        checkOutput("t6_mants",   32'(mants),    32'd0);
        checkOutput("t6_signs",   32'(signs),    32'd0);
        checkOutput("t6_outExp",  32'(outExp),   32'd0);
        checkOutput("t6_overrun", 32'(overrun),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t6_noDone",  32'(done),     32'd0);
        checkOutput("t6_noValid", 32'(validOut), 32'd0);
        applyStimulus(vecA, 8'd129);
        checkBeat("t6_new_b0", 23'h180000, 23'h280000, 2'b00, 1'b0);
        @(negedge clk);
        checkBeat("t6_new_b1", 23'h380000, 23'h480000, 2'b00, 1'b0);
        @(negedge clk);
        checkBeat("t6_new_b2", 23'h180000, 23'h280000, 2'b00, 1'b0);
        @(negedge clk);
        checkBeat("t6_new_b3", 23'h380000, 23'h480000, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("t6_new_idle", 32'(validOut), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
